// File: rtl/pulse_param_meter.sv
// pulse_param_meter
//   Measures a digitised rect/pulse waveform and reports, in clock cycles:
//   td (arm to first rising edge), th (high time), tl (low time) and
//   period = th + tl. Results leave through a valid/ready port.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   arm        start a measurement (1-cycle pulse), ignored while busy
//   cont       continuous re-measure after each report, sampled with arm
//   sig_in     digitised waveform, already synchronous to clk
//   clr_flags  clears the sticky timeout and overrun flags
//   m_valid    result valid
//   m_ready    consumer accepts the result
//   td/th/tl   measured durations, CW bits
//   period     th + tl, CW+1 bits
//   busy       a measurement is in progress
//   timeout    sticky: a duration counter saturated
//   overrun    sticky: a result was dropped because m_valid was pending
module pulse_param_meter #(
    parameter int unsigned CW   = 16,
    parameter int unsigned FILT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          cont,
    input  logic          sig_in,
    input  logic          clr_flags,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [CW-1:0] td,
    output logic [CW-1:0] th,
    output logic [CW-1:0] tl,
    output logic [CW:0]   period,
    output logic          busy,
    output logic          timeout,
    output logic          overrun
);

    localparam int unsigned FW = (FILT > 1) ? $clog2(FILT) : 1;
    // A count sitting one below all-ones means the next cycle would saturate.
    localparam logic [CW-1:0] CNT_SAT = {{(CW-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_HIGH,
        S_LOW,
        S_REPORT
    } state_e;

    // ---------------------------------------------------------------
    // Deglitch filter: level flips after FILT consecutive differing samples
    // ---------------------------------------------------------------
    logic          filt_q, filt_d;
    logic          filt_prev_q;
    logic [FW-1:0] diff_cnt_q, diff_cnt_d;

    always_comb begin
        filt_d     = filt_q;
        diff_cnt_d = '0;
        if (sig_in != filt_q) begin
            if (diff_cnt_q == FW'(FILT - 1)) begin
                filt_d = ~filt_q;
            end else begin
                diff_cnt_d = diff_cnt_q + FW'(1);
            end
        end
    end

    // Edges are taken one cycle after the flip, giving a fixed FILT latency
    // from the first differing raw sample for both polarities.
    logic rise_c, fall_c;
    assign rise_c = filt_q & ~filt_prev_q;
    assign fall_c = ~filt_q & filt_prev_q;

    // ---------------------------------------------------------------
    // Measurement FSM
    // ---------------------------------------------------------------
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          cont_q, cont_d;
    logic [CW-1:0] td_m_q, td_m_d;
    logic [CW-1:0] th_m_q, th_m_d;
    logic [CW-1:0] tl_m_q, tl_m_d;
    logic          set_to, set_ov, load;

    // Output registers
    logic          m_valid_q, m_valid_d;
    logic [CW-1:0] td_q, th_q, tl_q;
    logic [CW:0]   period_q;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;

    // Event value includes the event cycle itself.
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        cont_d  = cont_q;
        td_m_d  = td_m_q;
        th_m_d  = th_m_q;
        tl_m_d  = tl_m_q;
        set_to  = 1'b0;
        set_ov  = 1'b0;
        load    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (arm) begin
                    state_d = S_DELAY;
                    cont_d  = cont;
                end
            end
            S_DELAY: begin
                // Only a rise ends the delay, so a level already high at arm
                // is skipped over until it falls.
                if (cnt_q == CNT_SAT) begin
                    set_to  = 1'b1;
                    state_d = S_IDLE;
                end else if (rise_c) begin
                    td_m_d  = cnt_inc;
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (cnt_q == CNT_SAT) begin
                    set_to  = 1'b1;
                    state_d = S_IDLE;
                end else if (fall_c) begin
                    th_m_d  = cnt_inc;
                    cnt_d   = '0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (cnt_q == CNT_SAT) begin
                    set_to  = 1'b1;
                    state_d = S_IDLE;
                end else if (rise_c) begin
                    tl_m_d  = cnt_inc;
                    cnt_d   = '0;
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (m_valid_q) begin
                    set_ov = 1'b1;
                end else begin
                    load = 1'b1;
                end
                if (cont_q) begin
                    // The reporting rise already started the next high phase.
                    td_m_d = '0;
                    if (fall_c) begin
                        th_m_d  = cnt_inc;
                        cnt_d   = '0;
                        state_d = S_LOW;
                    end else begin
                        state_d = S_HIGH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result port, flags and busy
    always_comb begin
        m_valid_d = m_valid_q;
        if (load) begin
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        timeout_d = set_to | (timeout_q & ~clr_flags);
        overrun_d = set_ov | (overrun_q & ~clr_flags);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            diff_cnt_q  <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cont_q      <= 1'b0;
            td_m_q      <= '0;
            th_m_q      <= '0;
            tl_m_q      <= '0;
            m_valid_q   <= 1'b0;
            td_q        <= '0;
            th_q        <= '0;
            tl_q        <= '0;
            period_q    <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            diff_cnt_q  <= diff_cnt_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cont_q      <= cont_d;
            td_m_q      <= td_m_d;
            th_m_q      <= th_m_d;
            tl_m_q      <= tl_m_d;
            m_valid_q   <= m_valid_d;
            if (load) begin
                td_q     <= td_m_q;
                th_q     <= th_m_q;
                tl_q     <= tl_m_q;
                period_q <= {1'b0, th_m_q} + {1'b0, tl_m_q};
            end
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign m_valid = m_valid_q;
    assign td      = td_q;
    assign th      = th_q;
    assign tl      = tl_q;
    assign period  = period_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_pulse_param_meter.sv
// Testbench for pulse_param_meter: directed scenarios plus randomized
// waveforms, all checked against a timestamp-based reference model.
module tb_pulse_param_meter;

    localparam int unsigned CW   = 8;
    localparam int unsigned FILT = 2;
    localparam int          MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          arm;
    logic          cont;
    logic          sig_in;
    logic          clr_flags;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] td;
    logic [CW-1:0] th;
    logic [CW-1:0] tl;
    logic [CW:0]   period;
    logic          busy;
    logic          timeout;
    logic          overrun;

    pulse_param_meter #(.CW(CW), .FILT(FILT)) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .cont      (cont),
        .sig_in    (sig_in),
        .clr_flags (clr_flags),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .td        (td),
        .th        (th),
        .tl        (tl),
        .period    (period),
        .busy      (busy),
        .timeout   (timeout),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int edge_no = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: phases tracked by the timestamp of their start edge
    // ---------------------------------------------------------------
    typedef enum int {P_OFF, P_WAIT, P_HI, P_LO, P_REP} phase_e;
    phase_e ph;
    int     t_ref, r_td, r_th, r_tl;
    bit     r_cont;
    bit     f_lvl;
    int     f_run;
    int     f_flip;    // direction of the filtered flip at the previous edge: 0 none, 1 up, 2 down
    bit     e_valid, e_busy, e_to, e_ov;
    int     e_td, e_th, e_tl, e_per;

    task automatic model_reset();
        ph = P_OFF; t_ref = 0; r_td = 0; r_th = 0; r_tl = 0; r_cont = 1'b0;
        f_lvl = 1'b0; f_run = 0; f_flip = 0;
        e_valid = 1'b0; e_busy = 1'b0; e_to = 1'b0; e_ov = 1'b0;
        e_td = 0; e_th = 0; e_tl = 0; e_per = 0;
    endtask

    task automatic model_step();
        bit ev_up, ev_dn, set_to, set_ov, do_load;
        edge_no++;
        if (rst) begin
            model_reset();
            return;
        end
        ev_up = (f_flip == 1);
        ev_dn = (f_flip == 2);
        set_to = 1'b0; set_ov = 1'b0; do_load = 1'b0;
        case (ph)
            P_OFF: if (arm) begin ph = P_WAIT; t_ref = edge_no; r_cont = cont; end
            P_WAIT: begin
                if (edge_no - t_ref >= MAXC) begin set_to = 1'b1; ph = P_OFF; end
                else if (ev_up) begin r_td = edge_no - t_ref; t_ref = edge_no; ph = P_HI; end
            end
            P_HI: begin
                if (edge_no - t_ref >= MAXC) begin set_to = 1'b1; ph = P_OFF; end
                else if (ev_dn) begin r_th = edge_no - t_ref; t_ref = edge_no; ph = P_LO; end
            end
            P_LO: begin
                if (edge_no - t_ref >= MAXC) begin set_to = 1'b1; ph = P_OFF; end
                else if (ev_up) begin r_tl = edge_no - t_ref; t_ref = edge_no; ph = P_REP; end
            end
            P_REP: begin
                if (e_valid) set_ov = 1'b1; else do_load = 1'b1;
                if (do_load) begin
                    e_td = r_td; e_th = r_th; e_tl = r_tl; e_per = r_th + r_tl;
                end
                if (r_cont) begin
                    r_td = 0;
                    if (ev_dn) begin r_th = edge_no - t_ref; t_ref = edge_no; ph = P_LO; end
                    else ph = P_HI;
                end else begin
                    ph = P_OFF;
                end
            end
            default: ph = P_OFF;
        endcase
        if (do_load) e_valid = 1'b1;
        else if (e_valid && m_ready) e_valid = 1'b0;
        e_to   = set_to || (e_to && !clr_flags);
        e_ov   = set_ov || (e_ov && !clr_flags);
        e_busy = (ph != P_OFF);
        // filter: level follows the raw input after FILT consecutive differing samples
        f_flip = 0;
        if (sig_in != f_lvl) begin
            f_run++;
            if (f_run == FILT) begin
                f_lvl  = !f_lvl;
                f_flip = f_lvl ? 1 : 2;
                f_run  = 0;
            end
        end else begin
            f_run = 0;
        end
    endtask

    task automatic check_all();
        check_val("m_valid", 32'(m_valid), 32'(e_valid));
        check_val("busy",    32'(busy),    32'(e_busy));
        check_val("timeout", 32'(timeout), 32'(e_to));
        check_val("overrun", 32'(overrun), 32'(e_ov));
        check_val("td",      32'(td),      e_td);
        check_val("th",      32'(th),      e_th);
        check_val("tl",      32'(tl),      e_tl);
        check_val("period",  32'(period),  e_per);
    endtask

    // One clock: drive inputs, let the edge happen, step the model, compare on the falling edge
    task automatic cyc(input bit a, input bit c, input bit s, input bit clr, input bit rdy, input bit r);
        arm = a; cont = c; sig_in = s; clr_flags = clr; m_ready = rdy; rst = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic flush();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic bit wave(input int k, input int r0, input int f0, input int r1);
        return ((k >= r0) && (k < f0)) || (k >= r1);
    endfunction

    // Rise @8, fall @28, rise @48 with extra arm pulses while busy; optional glitch in the low span
    task automatic scen_basic(input bit glitch);
        bit s;
        for (int k = 0; k <= 55; k++) begin
            s = wave(k, 8, 28, 48) || (glitch && (k == 38));
            cyc((k == 0) || (k == 15) || (k == 40), 1'b0, s, 1'b0, 1'b0, 1'b0);
            if (k == 50) check_val("basic_valid_early", 32'(m_valid), 0);
            if (k == 51) begin
                check_val("basic_valid",  32'(m_valid), 1);
                check_val("basic_td",     32'(td), 10);
                check_val("basic_th",     32'(th), 20);
                check_val("basic_tl",     32'(tl), 20);
                check_val("basic_period", 32'(period), 40);
                check_val("basic_busy",   32'(busy), 0);
            end
        end
        check_val("basic_held", 32'(th), 20);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("basic_xfer", 32'(m_valid), 0);
        flush();
    endtask

    initial begin
        bit lvl;
        int rem, r;
        model_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("rst_valid",  32'(m_valid), 0);
        check_val("rst_busy",   32'(busy), 0);
        check_val("rst_period", 32'(period), 0);
        flush();

        // basic measurement, then the same with a 1-cycle glitch in the low span
        scen_basic(1'b0);
        scen_basic(1'b1);

        // arm coincides with a filtered rise while idle: that rise is skipped
        for (int k = -5; k <= 85; k++) begin
            cyc(k == 0, 1'b0, wave(k, -2, 18, 38) && !wave(k, 58, 78, 1000) || (k >= 78), 1'b0, 1'b0, 1'b0);
            if (k == 81) begin
                check_val("armrise_valid", 32'(m_valid), 1);
                check_val("armrise_td",    32'(td), 40);
                check_val("armrise_th",    32'(th), 20);
                check_val("armrise_tl",    32'(tl), 20);
            end
        end
        flush();

        // continuous mode with a stalled consumer
        for (int k = 0; k <= 135; k++) begin
            cyc(k == 0, 1'b1, wave(k, 8, 28, 1000) || wave(k, 48, 68, 1000) || wave(k, 88, 108, 1000)
                || (k >= 128), 1'b0, k == 100, 1'b0);
            if (k == 91) begin
                check_val("cont_overrun", 32'(overrun), 1);
                check_val("cont_held_td", 32'(td), 10);
                check_val("cont_held_v",  32'(m_valid), 1);
            end
            if (k == 100) check_val("cont_xfer", 32'(m_valid), 0);
            if (k == 131) begin
                check_val("cont_valid2", 32'(m_valid), 1);
                check_val("cont_td2",    32'(td), 0);
                check_val("cont_th2",    32'(th), 20);
                check_val("cont_tl2",    32'(tl), 20);
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        flush();

        // stuck-low input saturates the delay counter
        for (int k = 0; k <= 256; k++) begin
            cyc(k == 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (k == 254) begin
                check_val("to_early", 32'(timeout), 0);
                check_val("to_busy_early", 32'(busy), 1);
            end
            if (k == 255) begin
                check_val("to_set",   32'(timeout), 1);
                check_val("to_busy",  32'(busy), 0);
                check_val("to_valid", 32'(m_valid), 0);
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("to_clr", 32'(timeout), 0);
        flush();

        // reset in the middle of a high phase, then a clean re-run
        for (int k = 0; k <= 15; k++) begin
            cyc(k == 0, 1'b0, wave(k, 8, 28, 48), 1'b0, 1'b0, k == 15);
        end
        check_val("midrst_busy",  32'(busy), 0);
        check_val("midrst_valid", 32'(m_valid), 0);
        check_val("midrst_td",    32'(td), 0);
        flush();
        scen_basic(1'b0);

        // randomized waveforms, arms, handshakes, flag clears and resets
        lvl = 1'b0;
        rem = 10;
        for (int i = 0; i < 15000; i++) begin
            if (rem == 0) begin
                lvl = !lvl;
                r   = int'($urandom_range(0, 99));
                if (r < 8)       rem = 1;
                else if (r < 11) rem = int'($urandom_range(256, 300));
                else             rem = int'($urandom_range(2, 60));
            end
            rem--;
            cyc($urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)), lvl,
                $urandom_range(0, 149) == 0, $urandom_range(0, 99) < 60,
                $urandom_range(0, 2999) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
